// File: rtl/multicycle_right_shifter.sv
// -----------------------------------------------------------------------------
// multicycle_right_shifter
//
// Iterative 32-bit right shifter for the execute stage. A shift by 0..31 is
// built from five binary-weighted stages (16, 8, 4, 2, 1), one per clock, so
// the datapath needs only one 32-bit mux level. Latency is always 5 shift
// cycles plus one DONE cycle, whatever the shift amount.
//
// Ports
//   clock     in   1   single clock, rising edge
//   reset     in   1   synchronous, active-high
//   start     in   1   request; accepted only while ready=1
//   data_in   in  32   operand, captured on the accepting edge
//   shamt     in   5   shift amount, captured on the accepting edge
//   arith     in   1   1 = sign fill, 0 = zero fill; captured on accept
//   data_out  out 32   working register; final result valid while done=1 and
//                      held until the next accept
//   ready     out  1   high only in IDLE
//   done      out  1   one-cycle pulse marking a valid result
// -----------------------------------------------------------------------------
module multicycle_right_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;            // stage index: 4 -> shift by 16 ... 0 -> by 1
  logic [4:0]  shamt_q;
  logic        fill_q;         // bit shifted into vacated positions
  logic        stage_en;       // shamt_q bit selected by cnt
  logic [31:0] stage_shifted;  // working register shifted by 2^cnt

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register only, never from start.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Single shift stage: a 5-way mux selecting the weight for this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_en      = 1'b0;
    stage_shifted = data_out;
    case (cnt)
      3'd4: begin
        stage_en      = shamt_q[4];
        stage_shifted = {{16{fill_q}}, data_out[31:16]};
      end
      3'd3: begin
        stage_en      = shamt_q[3];
        stage_shifted = {{8{fill_q}}, data_out[31:8]};
      end
      3'd2: begin
        stage_en      = shamt_q[2];
        stage_shifted = {{4{fill_q}}, data_out[31:4]};
      end
      3'd1: begin
        stage_en      = shamt_q[1];
        stage_shifted = {{2{fill_q}}, data_out[31:2]};
      end
      3'd0: begin
        stage_en      = shamt_q[0];
        stage_shifted = {fill_q, data_out[31:1]};
      end
      default: begin
        stage_en      = 1'b0;
        stage_shifted = data_out;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. data_out doubles as the working register, so it moves
  // during SHIFT and simply holds through DONE and IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= 3'd0;
      data_out <= 32'h0000_0000;
      shamt_q  <= 5'd0;
      fill_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out <= data_in;
            shamt_q  <= shamt;
            // Sign fill only matters for arithmetic shifts; fold both into
            // one bit so the stage mux needs no extra select.
            fill_q   <= arith & data_in[31];
            cnt      <= 3'd4;
          end
        end
        SHIFT: begin
          if (stage_en) data_out <= stage_shifted;
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_right_shifter.sv
// -----------------------------------------------------------------------------
// tb_multicycle_right_shifter
//
// Self-checking bench for multicycle_right_shifter. Directed boundary cases
// and randomized operations are compared against a plain arithmetic model
// (>> and >>> on the captured operand). Inputs change #1 after the rising
// edge; outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_multicycle_right_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] data_out;
  logic        ready;
  logic        done;

  int checks   = 0;
  int failures = 0;

  multicycle_right_shifter dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .arith    (arith),
    .data_out (data_out),
    .ready    (ready),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: what a right shift means, not how the DUT builds it.
  function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                            input logic [4:0]  s,
                                            input logic        a);
    logic signed [31:0] sd;
    logic [31:0]        r;
    sd = d;
    if (a) r = sd >>> s;
    else   r = d >> s;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one operation, then walk the fixed 5-cycle latency checking the
  // handshake every cycle. With busy=1, start is pulsed with other operands
  // on shift cycles 2 and 4; those requests must be ignored.
  task automatic run_op(input string tag, input logic [31:0] d,
                        input logic [4:0] s, input logic a, input bit busy);
    logic [31:0] exp;
    int          done_seen;
    exp       = ref_shift(d, s, a);
    done_seen = 0;
    check({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    data_in = d;
    shamt   = s;
    arith   = a;
    start   = 1'b1;
    tick();                                  // E0: accept
    start   = 1'b0;
    data_in = $urandom;                      // operands are don't-care now
    shamt   = 5'($urandom);
    arith   = 1'($urandom);
    check({tag, "_ready_after_accept"}, {31'd0, ready}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      if (busy && (i == 2 || i == 4)) begin
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
        shamt   = 5'd1;
      end
      tick();                                // E1..E5
      start = 1'b0;
      if (done) done_seen++;
      check({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
      if (i < 5) check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    end
    check({tag, "_done_latency"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, data_out, exp);
    tick();                                  // E6: back to IDLE
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    check({tag, "_result_held"}, data_out, exp);
    check({tag, "_single_done"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  s;
    logic        a;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = 32'h0;
    shamt   = 5'd0;
    arith   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      check("rst_data_out", data_out, 32'h0000_0000);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      tick();
    end

    // Directed cases, including the boundary amounts.
    run_op("lsr4",        32'h8000_0000, 5'd4,  1'b0, 1'b0);
    check("lsr4_value",   data_out, 32'h0800_0000);
    run_op("asr4",        32'h8000_0000, 5'd4,  1'b1, 1'b0);
    check("asr4_value",   data_out, 32'hF800_0000);
    run_op("asr31_neg",   32'h8000_0000, 5'd31, 1'b1, 1'b0);
    check("asr31_neg_value", data_out, 32'hFFFF_FFFF);
    run_op("lsr31",       32'h8000_0000, 5'd31, 1'b0, 1'b0);
    check("lsr31_value",  data_out, 32'h0000_0001);
    run_op("asr31_pos",   32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0);
    check("asr31_pos_value", data_out, 32'h0000_0000);
    run_op("shift0",      32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0);
    check("shift0_value", data_out, 32'hDEAD_BEEF);

    // Start pulses while busy are ignored.
    run_op("busy",        32'h0000_00F0, 5'd4,  1'b0, 1'b1);
    check("busy_value",   data_out, 32'h0000_000F);
    tick();
    check("busy_not_queued", {31'd0, ready}, 32'd1);

    // Reset on the 3rd shift edge aborts the operation.
    data_in = 32'hCAFE_F00D;
    shamt   = 5'd7;
    arith   = 1'b1;
    start   = 1'b1;
    tick();                                  // E0
    start = 1'b0;
    tick();                                  // E1
    tick();                                  // E2
    reset = 1'b1;
    tick();                                  // E3 with reset
    reset = 1'b0;
    check("abort_data_out", data_out, 32'h0000_0000);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op("after_abort", 32'hCAFE_F00D, 5'd7, 1'b1, 1'b0);

    // Randomized operations, with the occasional idle gap.
    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      s = 5'($urandom);
      a = 1'($urandom);
      run_op("rand", d, s, a, 1'($urandom));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_right_shifter.md
# multicycle_right_shifter

Iterative 32-bit right shifter for the execute stage, complementing the existing left-shift path. Performs logical (zero-fill) or arithmetic (sign-fill) right shifts by 0–31 bit positions. It applies one binary-weighted stage (16, 8, 4, 2, 1) per clock, so it needs only a single 32-bit mux level and a fixed 5-cycle latency. A start/ready/done handshake lets the pipeline stall around it.

## Interface
- No parameters; width fixed at 32 bits, shift amount at 5 bits.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- start  input  1  request a shift; accepted only on an edge where ready=1.
- data_in  input  32  operand, captured on the accepting edge.
- shamt  input  5  shift amount 0–31, captured on the accepting edge.
- arith  input  1  1 = arithmetic (fill with captured data_in[31]), 0 = logical (fill with 0); captured on the accepting edge.
- data_out  output  32  result register; valid while done=1 and held until the next accepting edge.
- ready  output  1  1 only in IDLE.
- done  output  1  single-cycle pulse marking a valid result.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1, done=0.
  - On an edge with start=1, capture data_in into the working register, and capture shamt, arith and the sign bit.
  - Set stage counter cnt=4 and go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT: ready=0. Each edge does the following:
  - If captured shamt[cnt]=1, shift the working register right by 2^cnt. Vacated upper bits get the fill value (sign bit if arith, else 0). If shamt[cnt]=0, the register is unchanged.
  - If cnt=0, go to DONE. Otherwise cnt decrements.
  - Stage order: 16, 8, 4, 2, 1.
- DONE: done=1, ready=0. data_out equals the final working register. Next edge goes to IDLE.
- data_out is the working register itself: it updates during SHIFT, and the final value holds through DONE and IDLE until the next accept.
- All 5 stages always execute, including when shamt=0 (result = data_in) and shamt=31. There is no early exit.
- start while ready=0 is ignored; it is not queued.
- Operand inputs are don't-care except on the accepting edge.
- Logical-shift result equals data_in >> shamt. Arithmetic-shift result equals the signed data_in >>> shamt. No overflow or status flags.

## Timing
- Reset, on any edge with reset=1 and regardless of state:
  - state=IDLE, cnt=0, data_out=0x00000000, done=0, ready=1 from the following cycle.
  - Reset takes priority over start.
  - Reset mid-SHIFT or in DONE aborts the operation: no done pulse and no partial result is guaranteed.
- Latency: accepting edge E0; shift stages on E1–E5; done=1 in the cycle after E5; E6 returns to IDLE with ready=1.
- Start-to-start throughput is one operation per 7 cycles. The earliest next accept is E7; ready is already 1 in the cycle after E6.
- done is high for exactly one cycle per accepted operation.
- ready and done are never both 1.
- ready and done are registered (decoded from the state register only); they do not depend combinationally on start.

## Test plan
- Reset, then idle with start=0 for 3 cycles -> data_out=0x00000000, ready=1, done=0 throughout.
- Logical shift, data_in=0x80000000, shamt=4, arith=0 -> done=1 exactly 5 cycles after accept, data_out=0x08000000.
- Arithmetic shift, data_in=0x80000000, shamt=4, arith=1 -> data_out=0xF8000000.
- Boundary amounts:
  - data_in=0x80000000, shamt=31, arith=1 -> 0xFFFFFFFF.
  - Same with arith=0 -> 0x00000001.
  - data_in=0x7FFFFFFF, shamt=31, arith=1 -> 0x00000000.
  - data_in=0xDEADBEEF, shamt=0 -> 0xDEADBEEF after the full 5-cycle latency.
- Busy handling:
  - Accept data_in=0x000000F0, shamt=4, arith=0.
  - Pulse start with new operands (0xFFFFFFFF, shamt=1) on cycles 2 and 4.
  - Result -> a single done with data_out=0x0000000F, and ready=1 only after DONE.
- Reset mid-operation:
  - Accept a shift, assert reset on the 3rd SHIFT edge.
  - Required response: no done pulse, data_out=0x00000000, ready=1.
  - A new start then completes correctly.
